// File: rtl/mem_write_buffer.sv
// mem_write_buffer: write-through store FIFO between the caches and the RAM
// controller. Stores drain to RAM only while the controller is idle; cache
// misses are forwarded one at a time. A miss is held back while a buffered
// store targets the same 16-byte block, so a fill never returns stale data.
module mem_write_buffer #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req,
    input  logic [15:0]   wr_addr,
    input  logic [15:0]   wr_data,
    output logic          wr_ready,
    input  logic          i_miss_req,
    input  logic [15:0]   i_miss_addr,
    input  logic          d_miss_req,
    input  logic [15:0]   d_miss_addr,
    input  logic          ctrl_busy,
    output logic          ram_write,
    output logic [15:0]   ram_write_address,
    output logic [15:0]   ram_write_data,
    output logic          i_cache_miss,
    output logic [15:0]   i_cache_miss_address,
    output logic          d_cache_miss,
    output logic [15:0]   d_cache_miss_address,
    output logic [CW-1:0] buf_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t          state;
    logic            seen_busy;
    logic [15:0]     fifo_addr [DEPTH];
    logic [15:0]     fifo_data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            enq;
    logic            deq;
    logic            i_haz;
    logic            d_haz;

    assign wr_ready             = (count != CW'(DEPTH));
    assign enq                  = wr_req & wr_ready;
    assign deq                  = ram_write;
    assign ram_write_address    = fifo_addr[rd_ptr];
    assign ram_write_data       = fifo_data[rd_ptr];
    assign i_cache_miss_address = i_miss_addr;
    assign d_cache_miss_address = d_miss_addr;
    assign buf_count            = count;

    // Occupancy and block hazards as they will stand after this edge: the
    // head being written out no longer counts, a store arriving now does.
    // Outputs are registered, so the FSM decides on this look-ahead view.
    always_comb begin
        count_next = count + CW'(enq) - CW'(deq);
        i_haz      = enq && (wr_addr[15:4] == i_miss_addr[15:4]);
        d_haz      = enq && (wr_addr[15:4] == d_miss_addr[15:4]);
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid[k] && !(deq && (rd_ptr == AW'(k)))) begin
                if (fifo_addr[k][15:4] == i_miss_addr[15:4]) i_haz = 1'b1;
                if (fifo_addr[k][15:4] == d_miss_addr[15:4]) d_haz = 1'b1;
            end
        end
    end

    // Store FIFO: enqueue accepted stores, pop the head on each RAM write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                fifo_addr[k] <= '0;
                fifo_data[k] <= '0;
            end
        end else begin
            if (enq) begin
                fifo_addr[wr_ptr] <= wr_addr;
                fifo_data[wr_ptr] <= wr_data;
                valid[wr_ptr]     <= 1'b1;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (deq) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Arbiter between draining and miss forwarding; a forwarded miss is held
    // until the controller has been seen busy and then goes idle again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            seen_busy    <= 1'b0;
            ram_write    <= 1'b0;
            i_cache_miss <= 1'b0;
            d_cache_miss <= 1'b0;
        end else begin
            ram_write <= 1'b0;
            case (state)
                IDLE: begin
                    i_cache_miss <= 1'b0;
                    d_cache_miss <= 1'b0;
                    if (!ctrl_busy) begin
                        if (count_next == CW'(DEPTH)) begin
                            ram_write <= 1'b1;
                        end else if (d_miss_req && !d_haz) begin
                            d_cache_miss <= 1'b1;
                            state        <= WAIT_D;
                        end else if (i_miss_req && !i_haz) begin
                            i_cache_miss <= 1'b1;
                            state        <= WAIT_I;
                        end else if (count_next != '0) begin
                            ram_write <= 1'b1;
                        end
                    end
                end
                WAIT_I: begin
                    if (seen_busy && !ctrl_busy) begin
                        i_cache_miss <= 1'b0;
                        seen_busy    <= 1'b0;
                        state        <= IDLE;
                    end else if (ctrl_busy) begin
                        seen_busy <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (seen_busy && !ctrl_busy) begin
                        d_cache_miss <= 1'b0;
                        seen_busy    <= 1'b0;
                        state        <= IDLE;
                    end else if (ctrl_busy) begin
                        seen_busy <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: directed scenarios followed by
// randomized traffic, all checked every cycle against a queue-based model.
module tb_mem_write_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT_I = 1;
    localparam int M_WAIT_D = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req;
    logic [15:0]   wr_addr;
    logic [15:0]   wr_data;
    logic          wr_ready;
    logic          i_miss_req;
    logic [15:0]   i_miss_addr;
    logic          d_miss_req;
    logic [15:0]   d_miss_addr;
    logic          ctrl_busy;
    logic          ram_write;
    logic [15:0]   ram_write_address;
    logic [15:0]   ram_write_data;
    logic          i_cache_miss;
    logic [15:0]   i_cache_miss_address;
    logic          d_cache_miss;
    logic [15:0]   d_cache_miss_address;
    logic [CW-1:0] buf_count;

    mem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .wr_req               (wr_req),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .wr_ready             (wr_ready),
        .i_miss_req           (i_miss_req),
        .i_miss_addr          (i_miss_addr),
        .d_miss_req           (d_miss_req),
        .d_miss_addr          (d_miss_addr),
        .ctrl_busy            (ctrl_busy),
        .ram_write            (ram_write),
        .ram_write_address    (ram_write_address),
        .ram_write_data       (ram_write_data),
        .i_cache_miss         (i_cache_miss),
        .i_cache_miss_address (i_cache_miss_address),
        .d_cache_miss         (d_cache_miss),
        .d_cache_miss_address (d_cache_miss_address),
        .buf_count            (buf_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending stores as a queue of {addr, data}
    logic [31:0] q[$];
    int          m_state = M_IDLE;
    bit          m_seen  = 1'b0;
    bit          exp_rw  = 1'b0;
    bit          exp_im  = 1'b0;
    bit          exp_dm  = 1'b0;

    // Controller/cache environment used during random traffic
    int fill_phase = 0;
    int fill_cnt   = 0;
    bit fill_d     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit blk_pending(input logic [15:0] a);
        foreach (q[k]) if (q[k][31:20] == a[15:4]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sees.
    task automatic model_edge();
        bit enq;
        if (!rst_n) begin
            q.delete();
            m_state = M_IDLE;
            m_seen  = 1'b0;
            exp_rw  = 1'b0;
            exp_im  = 1'b0;
            exp_dm  = 1'b0;
            return;
        end
        enq = wr_req && (q.size() < DEPTH);
        if (exp_rw) q.delete(0);
        if (enq) q.push_back({wr_addr, wr_data});
        exp_rw = 1'b0;
        if (m_state == M_IDLE) begin
            exp_im = 1'b0;
            exp_dm = 1'b0;
            if (!ctrl_busy) begin
                if (q.size() == DEPTH) exp_rw = 1'b1;
                else if (d_miss_req && !blk_pending(d_miss_addr)) begin
                    exp_dm = 1'b1; m_state = M_WAIT_D;
                end else if (i_miss_req && !blk_pending(i_miss_addr)) begin
                    exp_im = 1'b1; m_state = M_WAIT_I;
                end else if (q.size() != 0) exp_rw = 1'b1;
            end
        end else begin
            if (m_seen && !ctrl_busy) begin
                exp_im = 1'b0; exp_dm = 1'b0; m_seen = 1'b0; m_state = M_IDLE;
            end else if (ctrl_busy) m_seen = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("ram_write", 32'(ram_write), 32'(exp_rw));
        chk("i_cache_miss", 32'(i_cache_miss), 32'(exp_im));
        chk("d_cache_miss", 32'(d_cache_miss), 32'(exp_dm));
        chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
        chk("buf_count", 32'(buf_count), 32'(q.size()));
        if (exp_rw && q.size() != 0) begin
            chk("ram_write_address", 32'(ram_write_address), 32'(q[0][31:16]));
            chk("ram_write_data", 32'(ram_write_data), 32'(q[0][15:0]));
        end
        if (exp_im) chk("i_cache_miss_address", 32'(i_cache_miss_address), 32'(i_miss_addr));
        if (exp_dm) chk("d_cache_miss_address", 32'(d_cache_miss_address), 32'(d_miss_addr));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        wr_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic finish_fill(input bit is_d);
        ctrl_busy = 1'b1;
        tick();
        tick();
        ctrl_busy = 1'b0;
        if (is_d) d_miss_req = 1'b0;
        else i_miss_req = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [15:0] rnd_addr();
        return {10'h000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
    endfunction

    task automatic ctrl_env();
        case (fill_phase)
            0: if (exp_im || exp_dm) begin
                fill_d = exp_dm; fill_cnt = $urandom_range(0, 2); fill_phase = 1;
            end
            1: if (fill_cnt == 0) begin
                ctrl_busy = 1'b1; fill_cnt = $urandom_range(0, 3); fill_phase = 2;
            end else fill_cnt--;
            2: if (fill_cnt == 0) begin
                ctrl_busy = 1'b0;
                if (fill_d) d_miss_req = 1'b0;
                else i_miss_req = 1'b0;
                fill_phase = 3;
            end else fill_cnt--;
            default: if (!exp_im && !exp_dm) fill_phase = 0;
        endcase
    endtask

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        i_miss_req = 1'b0; i_miss_addr = '0; d_miss_req = 1'b0; d_miss_addr = '0;
        ctrl_busy = 1'b0;
        tick();
        tick();
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_buf_count", 32'(buf_count), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // T2: three stores buffered while busy, then drained in order
        ctrl_busy = 1'b1;
        store(16'h0010, 16'hAAAA);
        store(16'h0020, 16'hBBBB);
        store(16'h0030, 16'hCCCC);
        chk("t2_count3", 32'(buf_count), 32'd3);
        ctrl_busy = 1'b0;
        tick();
        chk("t2_w1", {ram_write_address, ram_write_data}, 32'h0010AAAA);
        chk("t2_w1_strobe", 32'(ram_write), 32'd1);
        tick();
        chk("t2_w2", {ram_write_address, ram_write_data}, 32'h0020BBBB);
        chk("t2_w2_strobe", 32'(ram_write), 32'd1);
        tick();
        chk("t2_w3", {ram_write_address, ram_write_data}, 32'h0030CCCC);
        chk("t2_w3_strobe", 32'(ram_write), 32'd1);
        tick();
        chk("t2_done", {31'd0, ram_write}, 32'd0);
        chk("t2_count0", 32'(buf_count), 32'd0);
        idle(2);

        // T3: miss to a block with a pending store waits for the write
        store(16'h1234, 16'h0101);
        d_miss_req = 1'b1; d_miss_addr = 16'h123C;
        chk("t3_write_first", 32'(ram_write), 32'd1);
        chk("t3_write_addr", 32'(ram_write_address), 32'h1234);
        chk("t3_no_miss_yet", 32'(d_cache_miss), 32'd0);
        tick();
        chk("t3_miss_after", 32'(d_cache_miss), 32'd1);
        chk("t3_write_gone", 32'(ram_write), 32'd0);
        finish_fill(1'b1);
        idle(1);

        // T4: full buffer drops a fifth store and drains before a miss
        ctrl_busy = 1'b1;
        for (int k = 0; k < DEPTH; k++) store(16'((k + 1) * 16'h0100), 16'(16'h1000 + k));
        chk("t4_not_ready", 32'(wr_ready), 32'd0);
        store(16'h0500, 16'h5555);
        chk("t4_dropped", 32'(buf_count), 32'd4);
        d_miss_req = 1'b1; d_miss_addr = 16'h7000;
        ctrl_busy = 1'b0;
        tick();
        chk("t4_drain_first", 32'(ram_write), 32'd1);
        chk("t4_drain_addr", {ram_write_address, ram_write_data}, 32'h01001000);
        chk("t4_miss_held", 32'(d_cache_miss), 32'd0);
        tick();
        chk("t4_miss_next", 32'(d_cache_miss), 32'd1);
        chk("t4_count3", 32'(buf_count), 32'd3);
        finish_fill(1'b1);
        idle(5);
        chk("t4_empty", 32'(buf_count), 32'd0);

        // T5: D beats I; I follows after exactly one idle cycle
        i_miss_req = 1'b1; i_miss_addr = 16'h0400;
        d_miss_req = 1'b1; d_miss_addr = 16'h0800;
        tick();
        chk("t5_d_first", {30'd0, d_cache_miss, i_cache_miss}, 32'd2);
        tick();
        ctrl_busy = 1'b1;
        tick();
        tick();
        ctrl_busy = 1'b0; d_miss_req = 1'b0;
        tick();
        chk("t5_gap", {30'd0, d_cache_miss, i_cache_miss}, 32'd0);
        tick();
        chk("t5_i_next", {30'd0, d_cache_miss, i_cache_miss}, 32'd1);
        finish_fill(1'b0);

        // T6: a D miss cannot preempt an I fill in progress
        i_miss_req = 1'b1; i_miss_addr = 16'h0A00;
        tick();
        chk("t6_i_fwd", 32'(i_cache_miss), 32'd1);
        d_miss_req = 1'b1; d_miss_addr = 16'h0B00;
        tick();
        chk("t6_no_d_1", 32'(d_cache_miss), 32'd0);
        ctrl_busy = 1'b1;
        tick();
        chk("t6_no_d_2", 32'(d_cache_miss), 32'd0);
        tick();
        ctrl_busy = 1'b0; i_miss_req = 1'b0;
        tick();
        chk("t6_gap", {30'd0, d_cache_miss, i_cache_miss}, 32'd0);
        tick();
        chk("t6_d_after", 32'(d_cache_miss), 32'd1);
        finish_fill(1'b1);

        // T1: asynchronous reset in the middle of a fill
        d_miss_req = 1'b1; d_miss_addr = 16'h0900;
        tick();
        store(16'h0050, 16'h7777);
        ctrl_busy = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t1_outputs", {29'd0, ram_write, i_cache_miss, d_cache_miss}, 32'd0);
        chk("t1_wr_ready", 32'(wr_ready), 32'd1);
        chk("t1_buf_count", 32'(buf_count), 32'd0);
        chk("t1_head", {ram_write_address, ram_write_data}, 32'd0);
        d_miss_req = 1'b0; ctrl_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic with a reactive controller
        for (int n = 0; n < 3000; n++) begin
            wr_req  = ($urandom_range(0, 2) == 0);
            wr_addr = rnd_addr();
            wr_data = 16'($urandom);
            ctrl_env();
            if (fill_phase == 0 && !d_miss_req && $urandom_range(0, 7) == 0) begin
                d_miss_req = 1'b1; d_miss_addr = rnd_addr();
            end
            if (fill_phase == 0 && !i_miss_req && $urandom_range(0, 7) == 0) begin
                i_miss_req = 1'b1; i_miss_addr = rnd_addr();
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
